// File: rtl/gwaihirs_button_counter.sv
// Push-button front end: synchronisers, debouncer, press edge detector
// and a wrapping up/down counter with step and wrap strobes.
module gwaihirs_button_counter #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             dir_in,
  input  logic             clr_in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             wrap
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] dir_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   btn_s;
  logic                   dir_s;
  logic                   clr_s;
  logic                   btn_db;
  logic                   btn_db_q;
  logic [DBW-1:0]         db_cnt;
  logic                   press;
  logic                   at_max;
  logic                   at_min;

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign dir_s  = dir_sync[SYNC_STAGES-1];
  assign clr_s  = clr_sync[SYNC_STAGES-1];
  assign press  = btn_db & ~btn_db_q;
  assign at_max = &count;
  assign at_min = ~|count;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync <= '0;
      dir_sync <= '0;
      clr_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in};
      dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir_in};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_in};
    end
  end

  // New level must hold DEBOUNCE_CYCLES consecutive cycles to be taken
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      step_pulse <= press;
      wrap       <= 1'b0;
      if (clr_s) begin
        count <= '0;
      end else if (press && en) begin
        if (dir_s) begin
          count <= count + WIDTH'(1);
          wrap  <= at_max;
        end else begin
          count <= count - WIDTH'(1);
          wrap  <= at_min;
        end
      end
    end
  end

endmodule

// File: tb/tb_gwaihirs_button_counter.sv
// Directed bench for gwaihirs_button_counter with default parameters
// (S=2, D=4, WIDTH=8); expected values are hand-derived.
module tb_gwaihirs_button_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       dir_in;
  logic       clr_in;
  logic       en;
  logic [7:0] count;
  logic       step_pulse;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  gwaihirs_button_counter dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .dir_in     (dir_in),
    .clr_in     (clr_in),
    .en         (en),
    .count      (count),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press for `hold` cycles then release for 8; tally strobes seen.
  task automatic press(input int hold, output int steps,
                       output int wraps, output int both);
    steps = 0;
    wraps = 0;
    both  = 0;
    btn_in = 1'b1;
    for (int i = 0; i < hold + 8; i++) begin
      if (i == hold) btn_in = 1'b0;
      tick();
      if (step_pulse === 1'b1) steps++;
      if (wrap === 1'b1) wraps++;
      if (step_pulse === 1'b1 && wrap === 1'b1) both++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    dir_in = 1'b1;
    clr_in = 1'b0;
    en = 1'b1;
    idle(3);
    n_cmp++;
    if (count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    n_cmp++;
    if (step_pulse !== 1'b0 || wrap !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobes got step=%b wrap=%b want 0 0",
               step_pulse, wrap);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_press();
    int extra;
    extra = 0;
    btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) begin
        n_cmp++;
        if (count !== 8'd0 || step_pulse !== 1'b0) begin
          n_err++;
          $display("FAIL press_early got count=%0d step=%b want 0 0",
                   count, step_pulse);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (count !== 8'd1 || step_pulse !== 1'b1) begin
          n_err++;
          $display("FAIL press_edge7 got count=%0d step=%b want 1 1",
                   count, step_pulse);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (step_pulse !== 1'b0) begin
          n_err++;
          $display("FAIL press_one_cycle got step=%b want 0", step_pulse);
        end
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step_pulse !== 1'b0) extra++;
    end
    n_cmp++;
    if (count !== 8'd1 || extra !== 0) begin
      n_err++;
      $display("FAIL release got count=%0d steps=%0d want 1 0",
               count, extra);
    end
  endtask

  task automatic test_glitch();
    int steps;
    int w;
    int b;
    steps = 0;
    btn_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 3) btn_in = 1'b0;
      if (i == 4) btn_in = 1'b1;
      if (i == 7) btn_in = 1'b0;
      tick();
      if (step_pulse === 1'b1) steps++;
    end
    n_cmp++;
    if (count !== 8'd1 || steps !== 0) begin
      n_err++;
      $display("FAIL glitch got count=%0d steps=%0d want 1 0",
               count, steps);
    end
    press(4, steps, w, b);
    n_cmp++;
    if (count !== 8'd2 || steps !== 1) begin
      n_err++;
      $display("FAIL hold4 got count=%0d steps=%0d want 2 1",
               count, steps);
    end
  endtask

  task automatic test_wrap();
    int s;
    int w;
    int b;
    int st = 0;
    int wt = 0;
    for (int i = 0; i < 253; i++) begin
      press(5, s, w, b);
      st += s;
      wt += w;
    end
    n_cmp++;
    if (count !== 8'd255 || st !== 253 || wt !== 0) begin
      n_err++;
      $display("FAIL preload got count=%0d steps=%0d wraps=%0d want 255 253 0",
               count, st, wt);
    end
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd0 || w !== 1 || b !== 1) begin
      n_err++;
      $display("FAIL wrap_up got count=%0d wraps=%0d both=%0d want 0 1 1",
               count, w, b);
    end
    dir_in = 1'b0;
    idle(3);
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd255 || w !== 1 || b !== 1) begin
      n_err++;
      $display("FAIL wrap_down got count=%0d wraps=%0d both=%0d want 255 1 1",
               count, w, b);
    end
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd254 || w !== 0 || s !== 1) begin
      n_err++;
      $display("FAIL down_step got count=%0d wraps=%0d steps=%0d want 254 0 1",
               count, w, s);
    end
  endtask

  task automatic test_en_clr();
    int s;
    int w;
    int b;
    en = 1'b0;
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd254 || s !== 1 || w !== 0) begin
      n_err++;
      $display("FAIL en_off got count=%0d steps=%0d wraps=%0d want 254 1 0",
               count, s, w);
    end
    en = 1'b1;
    clr_in = 1'b1;
    idle(3);
    n_cmp++;
    if (count !== 8'd0) begin
      n_err++;
      $display("FAIL clear got count=%0d want 0", count);
    end
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd0 || s !== 1 || w !== 0) begin
      n_err++;
      $display("FAIL clr_down got count=%0d steps=%0d wraps=%0d want 0 1 0",
               count, s, w);
    end
    dir_in = 1'b1;
    idle(3);
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd0 || s !== 1 || w !== 0) begin
      n_err++;
      $display("FAIL clr_up got count=%0d steps=%0d wraps=%0d want 0 1 0",
               count, s, w);
    end
    clr_in = 1'b0;
    idle(3);
    press(5, s, w, b);
    n_cmp++;
    if (count !== 8'd1 || s !== 1) begin
      n_err++;
      $display("FAIL after_clr got count=%0d steps=%0d want 1 1",
               count, s);
    end
  endtask

  task automatic test_reset_mid();
    int steps = 0;
    btn_in = 1'b1;
    idle(4);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'd0 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got count=%0d step=%b wrap=%b want 0 0 0",
               count, step_pulse, wrap);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (step_pulse !== 1'b0 || count !== 8'd0) steps++;
    end
    n_cmp++;
    if (steps !== 0) begin
      n_err++;
      $display("FAIL rst_early got %0d early changes want 0", steps);
    end
    tick();
    n_cmp++;
    if (count !== 8'd1 || step_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL rst_edge7 got count=%0d step=%b want 1 1",
               count, step_pulse);
    end
    steps = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) btn_in = 1'b0;
      tick();
      if (step_pulse === 1'b1) steps++;
    end
    n_cmp++;
    if (count !== 8'd1 || steps !== 0) begin
      n_err++;
      $display("FAIL rst_single got count=%0d steps=%0d want 1 0",
               count, steps);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_wrap();
    test_en_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
